// File: rtl/dll_pkg.sv
// Shared types and constants for the data link control/management state machine.
package dll_pkg;

  typedef enum logic [1:0] {
    DL_INACTIVE = 2'd0,
    DL_INIT1    = 2'd1,
    DL_INIT2    = 2'd2,
    DL_ACTIVE   = 2'd3
  } dlcm_state_t;

  typedef enum logic [1:0] {
    FC_KIND_INIT1  = 2'd0,
    FC_KIND_INIT2  = 2'd1,
    FC_KIND_UPDATE = 2'd2,
    FC_KIND_NONE   = 2'd3
  } fc_kind_t;

  typedef enum logic [1:0] {
    FC_P         = 2'd0,
    FC_NP        = 2'd1,
    FC_CPL       = 2'd2,
    FC_TYPE_NONE = 2'd3
  } fc_type_t;

  localparam int unsigned RESEND_CYCLES_DEFAULT = 8500;

endpackage

// File: rtl/dll_fc_seq.sv
// InitFC DLLP sequencer: walks VC 0..NUM_VC-1 x {P,NP,Cpl} with a req/ack
// handshake, then waits RESEND_CYCLES idle cycles before repeating.
module dll_fc_seq
  import dll_pkg::*;
#(
  parameter int unsigned NUM_VC        = 1,
  parameter int unsigned VC_W          = 3,
  parameter int unsigned RESEND_CYCLES = RESEND_CYCLES_DEFAULT
) (
  input  logic            clk,
  input  logic            srst,
  input  logic            run,
  input  logic            start,
  input  logic            phase_i,
  input  logic            ack_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            phase_o,
  output fc_type_t        type_o,
  output logic [VC_W-1:0] vc_o
);

  localparam int unsigned     TW       = $clog2(RESEND_CYCLES);
  localparam logic [VC_W-1:0] LAST_VC  = VC_W'(NUM_VC - 1);
  localparam logic [TW-1:0]   TMR_LAST = TW'(RESEND_CYCLES - 1);

  typedef enum logic [1:0] {SQ_IDLE, SQ_SEND, SQ_WAIT} seq_state_t;

  seq_state_t      st_q, st_d;
  logic [VC_W-1:0] vc_q, vc_d;
  fc_type_t        ty_q, ty_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            ph_q, ph_d;

  assign busy_o  = (st_q == SQ_SEND);
  assign done_o  = busy_o && ack_i && (ty_q == FC_CPL) && (vc_q == LAST_VC);
  assign phase_o = ph_q;
  assign type_o  = ty_q;
  assign vc_o    = vc_q;

  always_comb begin
    st_d  = st_q;
    vc_d  = vc_q;
    ty_d  = ty_q;
    tmr_d = tmr_q;
    ph_d  = ph_q;
    case (st_q)
      SQ_SEND: begin
        if (ack_i) begin
          if (ty_q == FC_CPL) begin
            ty_d = FC_P;
            if (vc_q == LAST_VC) begin
              vc_d  = '0;
              tmr_d = '0;
              st_d  = SQ_WAIT;
            end else begin
              vc_d = vc_q + VC_W'(1);
            end
          end else begin
            ty_d = fc_type_t'(ty_q + 2'd1);
          end
        end
      end
      SQ_WAIT: begin
        if (tmr_q == TMR_LAST) st_d = SQ_SEND;
        else                   tmr_d = tmr_q + TW'(1);
      end
      default: ;
    endcase
    // A start coinciding with the last ack restarts at once, skipping the resend wait.
    if (start) begin
      st_d  = SQ_SEND;
      vc_d  = '0;
      ty_d  = FC_P;
      tmr_d = '0;
      ph_d  = phase_i;
    end
    if (!run) begin
      st_d  = SQ_IDLE;
      vc_d  = '0;
      ty_d  = FC_P;
      tmr_d = '0;
      ph_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      st_q  <= SQ_IDLE;
      vc_q  <= '0;
      ty_q  <= FC_P;
      tmr_q <= '0;
      ph_q  <= 1'b0;
    end else begin
      st_q  <= st_d;
      vc_q  <= vc_d;
      ty_q  <= ty_d;
      tmr_q <= tmr_d;
      ph_q  <= ph_d;
    end
  end

endmodule

// File: rtl/dll_dlcmsm_mvc.sv
// Data Link Control and Management State Machine with multi-VC FC init:
// tracks FI1/FI2 per VC and steps DL_Inactive -> FC_INIT1 -> FC_INIT2 -> DL_Active.
module dll_dlcmsm_mvc
  import dll_pkg::*;
#(
  parameter int unsigned NUM_VC        = 1,
  parameter int unsigned VC_W          = 3,
  parameter int unsigned RESEND_CYCLES = RESEND_CYCLES_DEFAULT
) (
  input  logic                ssclk,
  input  logic                srst,
  input  logic                pl_link_up_i,
  input  logic                rx_fc_valid_i,
  input  logic [1:0]          rx_fc_kind_i,
  input  logic [1:0]          rx_fc_type_i,
  input  logic [VC_W-1:0]     rx_fc_vc_i,
  output logic                tx_fc_req_o,
  input  logic                tx_fc_ack_i,
  output logic                tx_fc_phase2_o,
  output logic [1:0]          tx_fc_type_o,
  output logic [VC_W-1:0]     tx_fc_vc_o,
  output logic [1:0]          state_o,
  output logic                link_up_o,
  output logic                dl_active_o,
  output logic [2*NUM_VC-1:0] fi_flags_o
);

  dlcm_state_t         state_q, state_d;
  logic [3*NUM_VC-1:0] fi1_sub_q, fi1_sub_d, fi1_set;
  logic [NUM_VC-1:0]   fi2_q, fi2_d, fi2_set, fi1_q;
  logic                rec_fi1, rec_fi2, all_fi1, all_fi2;
  logic                seq_run, seq_start, seq_phase, seq_busy, seq_done, seq_phase_o;
  fc_type_t            seq_type;
  logic [VC_W-1:0]     seq_vc;
  fc_kind_t            rx_kind;

  assign rx_kind = fc_kind_t'(rx_fc_kind_i);

  // Incoming sets are ORed in before the end-of-sequence check so an rx
  // landing on the last ack still counts for this sequence.
  always_comb begin
    fi1_set = '0;
    fi2_set = '0;
    fi1_q   = '0;
    all_fi1 = 1'b1;
    rec_fi1 = rx_fc_valid_i &&
              (((state_q == DL_INIT1) && (rx_kind == FC_KIND_INIT1)) ||
               ((state_q == DL_INIT2) && ((rx_kind == FC_KIND_INIT1) || (rx_kind == FC_KIND_INIT2))));
    rec_fi2 = rx_fc_valid_i && (state_q == DL_INIT2) &&
              ((rx_kind == FC_KIND_INIT2) || (rx_kind == FC_KIND_UPDATE));
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      for (int unsigned t = 0; t < 3; t++) begin
        if ((rx_fc_vc_i == VC_W'(v)) && (rx_fc_type_i == 2'(t))) begin
          fi1_set[3*v+t] = rec_fi1;
          fi2_set[v]     = fi2_set[v] | rec_fi2;
        end
      end
    end
    fi1_sub_d = fi1_sub_q | fi1_set;
    fi2_d     = fi2_q | fi2_set;
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      fi1_q[v] = &fi1_sub_q[3*v +: 3];
      all_fi1  = all_fi1 & (&fi1_sub_d[3*v +: 3]);
    end
    all_fi2 = &fi2_d;
  end

  always_comb begin
    state_d   = state_q;
    seq_start = 1'b0;
    seq_phase = 1'b0;
    case (state_q)
      DL_INACTIVE: begin
        state_d   = DL_INIT1;
        seq_start = 1'b1;
      end
      DL_INIT1: begin
        if (seq_done && all_fi1) begin
          state_d   = DL_INIT2;
          seq_start = 1'b1;
          seq_phase = 1'b1;
        end
      end
      DL_INIT2: begin
        if (seq_done && all_fi2) state_d = DL_ACTIVE;
      end
      default: ;
    endcase
    if (!pl_link_up_i) begin
      state_d   = DL_INACTIVE;
      seq_start = 1'b0;
    end
    seq_run = (state_d == DL_INIT1) || (state_d == DL_INIT2);
  end

  always_ff @(posedge ssclk) begin
    if (srst) begin
      state_q   <= DL_INACTIVE;
      fi1_sub_q <= '0;
      fi2_q     <= '0;
    end else begin
      state_q <= state_d;
      if (!pl_link_up_i) begin
        fi1_sub_q <= '0;
        fi2_q     <= '0;
      end else begin
        fi1_sub_q <= fi1_sub_d;
        fi2_q     <= fi2_d;
      end
    end
  end

  dll_fc_seq #(
    .NUM_VC        (NUM_VC),
    .VC_W          (VC_W),
    .RESEND_CYCLES (RESEND_CYCLES)
  ) u_seq (
    .clk     (ssclk),
    .srst    (srst),
    .run     (seq_run),
    .start   (seq_start),
    .phase_i (seq_phase),
    .ack_i   (tx_fc_ack_i),
    .busy_o  (seq_busy),
    .done_o  (seq_done),
    .phase_o (seq_phase_o),
    .type_o  (seq_type),
    .vc_o    (seq_vc)
  );

  assign tx_fc_req_o    = seq_busy && pl_link_up_i;
  assign tx_fc_phase2_o = seq_phase_o;
  assign tx_fc_type_o   = seq_type;
  assign tx_fc_vc_o     = seq_vc;
  assign state_o        = state_q;
  assign link_up_o      = (state_q == DL_INIT2) || (state_q == DL_ACTIVE);
  assign dl_active_o    = (state_q == DL_ACTIVE);
  assign fi_flags_o     = {fi2_q, fi1_q};

endmodule

// File: tb/tb_dll_dlcmsm_mvc.sv
// Bench for dll_dlcmsm_mvc: directed scenarios plus random traffic, all checked
// every cycle against a DLLP-index-based behavioural model.
module tb_dll_dlcmsm_mvc;

  localparam int unsigned NV      = 2;
  localparam int unsigned VW      = 3;
  localparam int unsigned RS      = 4;
  localparam int          SEQ_LEN = 3 * NV;

  logic          ssclk = 1'b0;
  logic          srst, pl_link_up_i, rx_fc_valid_i, tx_fc_ack_i;
  logic [1:0]    rx_fc_kind_i, rx_fc_type_i;
  logic [VW-1:0] rx_fc_vc_i;
  logic          tx_fc_req_o, tx_fc_phase2_o, link_up_o, dl_active_o;
  logic [1:0]    tx_fc_type_o, state_o;
  logic [VW-1:0] tx_fc_vc_o;
  logic [2*NV-1:0] fi_flags_o;

  always #5 ssclk = ~ssclk;

  dll_dlcmsm_mvc #(.NUM_VC(NV), .VC_W(VW), .RESEND_CYCLES(RS)) dut (
    .ssclk(ssclk), .srst(srst), .pl_link_up_i(pl_link_up_i),
    .rx_fc_valid_i(rx_fc_valid_i), .rx_fc_kind_i(rx_fc_kind_i),
    .rx_fc_type_i(rx_fc_type_i), .rx_fc_vc_i(rx_fc_vc_i),
    .tx_fc_req_o(tx_fc_req_o), .tx_fc_ack_i(tx_fc_ack_i),
    .tx_fc_phase2_o(tx_fc_phase2_o), .tx_fc_type_o(tx_fc_type_o),
    .tx_fc_vc_o(tx_fc_vc_o), .state_o(state_o), .link_up_o(link_up_o),
    .dl_active_o(dl_active_o), .fi_flags_o(fi_flags_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model: link state, received-flag sets, and the index of the DLLP being
  // offered within the current sequence (vc = k/3, type = k%3).
  int       m_state;
  bit [2:0] m_f1 [NV];
  bit       m_f2 [NV];
  bit       m_send;
  int       m_k;
  int       m_gap;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] exp_fi();
    logic [31:0] r = '0;
    for (int v = 0; v < NV; v++) begin
      r[v]      = &m_f1[v];
      r[NV + v] = m_f2[v];
    end
    return r;
  endfunction

  task automatic model_reset();
    m_state = 0; m_send = 0; m_k = 0; m_gap = 0;
    for (int v = 0; v < NV; v++) begin m_f1[v] = '0; m_f2[v] = 0; end
  endtask

  task automatic model_step();
    bit all1, all2;
    if (srst || !pl_link_up_i) begin model_reset(); return; end
    if (rx_fc_valid_i && rx_fc_type_i < 3 && rx_fc_vc_i < NV) begin
      if ((m_state == 1 && rx_fc_kind_i == 0) || (m_state == 2 && rx_fc_kind_i <= 1))
        m_f1[rx_fc_vc_i][rx_fc_type_i] = 1;
      if (m_state == 2 && (rx_fc_kind_i == 1 || rx_fc_kind_i == 2))
        m_f2[rx_fc_vc_i] = 1;
    end
    all1 = 1; all2 = 1;
    for (int v = 0; v < NV; v++) begin all1 &= &m_f1[v]; all2 &= m_f2[v]; end
    case (m_state)
      0: begin m_state = 1; m_send = 1; m_k = 0; end
      1, 2: begin
        if (m_send) begin
          if (tx_fc_ack_i) begin
            if (m_k == SEQ_LEN - 1) begin
              if (m_state == 1 && all1)      begin m_state = 2; m_k = 0; end
              else if (m_state == 2 && all2) begin m_state = 3; m_send = 0; end
              else                           begin m_send = 0; m_gap = RS; end
            end else m_k++;
          end
        end else begin
          m_gap--;
          if (m_gap == 0) begin m_send = 1; m_k = 0; end
        end
      end
      default: ;
    endcase
  endtask

  task automatic compare_all();
    chk("state", state_o, m_state);
    chk("link_up", link_up_o, m_state >= 2);
    chk("dl_active", dl_active_o, m_state == 3);
    chk("fi_flags", fi_flags_o, exp_fi());
    chk("req", tx_fc_req_o, m_send && pl_link_up_i);
    if (m_send && pl_link_up_i) begin
      chk("phase", tx_fc_phase2_o, m_state == 2);
      chk("type", tx_fc_type_o, m_k % 3);
      chk("vc", tx_fc_vc_o, m_k / 3);
    end
  endtask

  // Inputs are set at the falling edge; outputs checked 1 ns later, model
  // advanced on the rising edge.
  task automatic tick();
    #1 compare_all();
    @(posedge ssclk);
    model_step();
    @(negedge ssclk);
  endtask

  task automatic rx(input bit vld, input int kind, input int typ, input int vc);
    rx_fc_valid_i = vld;
    rx_fc_kind_i  = 2'(kind);
    rx_fc_type_i  = 2'(typ);
    rx_fc_vc_i    = VW'(vc);
  endtask

  initial begin
    srst = 1; pl_link_up_i = 0; tx_fc_ack_i = 0;
    rx(0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge ssclk);
    @(negedge ssclk);
    tick();
    srst = 0;
    tick();
    chk("rst_state", state_o, 0);
    chk("rst_fi", fi_flags_o, 0);
    chk("rst_req", tx_fc_req_o, 0);
    chk("rst_link_up", link_up_o, 0);

    // Link up with ack always high: back-to-back InitFC1, then a 4-cycle gap.
    pl_link_up_i = 1; tx_fc_ack_i = 1;
    tick();
    chk("init1_state", state_o, 1);
    chk("init1_req", tx_fc_req_o, 1);
    chk("init1_vc", tx_fc_vc_o, 0);
    chk("init1_type", tx_fc_type_o, 0);
    chk("init1_phase", tx_fc_phase2_o, 0);
    repeat (SEQ_LEN) tick();
    chk("gap_first", tx_fc_req_o, 0);
    repeat (RS - 1) tick();
    chk("gap_last", tx_fc_req_o, 0);
    tick();
    chk("resend_req", tx_fc_req_o, 1);
    chk("resend_type", tx_fc_type_o, 0);

    // All InitFC1 arrive during the sequence; the last one coincides with the last ack.
    for (int v = 0; v < NV; v++)
      for (int t = 0; t < 3; t++) begin rx(1, 0, t, v); tick(); end
    rx(0, 0, 0, 0);
    chk("init2_state", state_o, 2);
    chk("init2_link_up", link_up_o, 1);
    chk("init2_req", tx_fc_req_o, 1);
    chk("init2_phase", tx_fc_phase2_o, 1);
    chk("init2_vc", tx_fc_vc_o, 0);

    rx(1, 2, 0, 0); tick();
    rx(1, 1, 0, 1); tick();
    rx(0, 0, 0, 0);
    repeat (SEQ_LEN - 2) tick();
    chk("active_state", state_o, 3);
    chk("active_dl", dl_active_o, 1);
    repeat (8) tick();
    chk("active_no_req", tx_fc_req_o, 0);

    pl_link_up_i = 0; tick();
    chk("down_state", state_o, 0);
    chk("down_link_up", link_up_o, 0);
    chk("down_fi", fi_flags_o, 0);
    pl_link_up_i = 1; tick();
    chk("relink_req", tx_fc_req_o, 1);
    chk("relink_vc", tx_fc_vc_o, 0);
    chk("relink_phase", tx_fc_phase2_o, 0);

    // Stall the ack on VC1 NP.
    for (int i = 0; i < 20 && !(m_send && m_k == 4); i++) tick();
    chk("stall_vc", tx_fc_vc_o, 1);
    tx_fc_ack_i = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_req", tx_fc_req_o, 1);
      chk("stall_vc_hold", tx_fc_vc_o, 1);
      chk("stall_type_hold", tx_fc_type_o, 1);
    end
    tx_fc_ack_i = 1;

    // VC1 never gets InitFC1 Cpl: stays in INIT1 while resending.
    for (int i = 0; i < 5; i++) begin rx(1, 0, i % 3, i / 3); tick(); end
    rx(0, 0, 0, 0);
    for (int i = 0; i < 60; i++) begin tx_fc_ack_i = ($urandom % 3) != 0; tick(); end
    chk("stuck_init1", state_o, 1);

    rx(1, 0, 2, 1); tick(); rx(0, 0, 0, 0);
    tx_fc_ack_i = 1;
    for (int i = 0; i < 40 && m_state != 2; i++) tick();
    chk("reach_init2", state_o, 2);
    tx_fc_ack_i = 0; tick();
    chk("init2_pending", tx_fc_req_o, 1);
    pl_link_up_i = 0; tick();
    chk("drop_state", state_o, 0);
    chk("drop_link_up", link_up_o, 0);
    chk("drop_fi", fi_flags_o, 0);
    chk("drop_req", tx_fc_req_o, 0);

    // Reset with a pending request, then out-of-range VC traffic.
    pl_link_up_i = 1; tick();
    chk("pre_srst_req", tx_fc_req_o, 1);
    srst = 1; tick();
    chk("srst_state", state_o, 0);
    chk("srst_req", tx_fc_req_o, 0);
    chk("srst_vc", tx_fc_vc_o, 0);
    srst = 0; tick();
    for (int t = 0; t < 3; t++) begin rx(1, 0, t, 5); tick(); end
    rx(0, 0, 0, 0);
    chk("vc5_ignored", fi_flags_o, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      srst = ($urandom % 400) == 0;
      if (pl_link_up_i) pl_link_up_i = ($urandom % 150) != 0;
      else              pl_link_up_i = ($urandom % 4) == 0;
      tx_fc_ack_i = ($urandom % 4) != 0;
      rx($urandom % 2, $urandom % 4, $urandom % 4,
         (($urandom % 8) == 0) ? $urandom % 8 : $urandom % NV);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
